// File: rtl/rx_source_sel.sv
// rx_source_sel
//   Receive-side per-channel source selector and test-pattern generator that
//   sits between the DDC chains and rx_buffer. Each baseband channel (I and Q
//   counted separately) independently outputs DDC data, latched TX loopback
//   data, a ramp counter, or a shared 15-bit PRBS. The mode register is written
//   over the serial settings bus and is applied only on a sample strobe.
//
// Parameters
//   NCHAN  number of baseband channels, 1..8
//   WIDTH  sample width in bits, 15..32
//   ADDR   serial settings address of the mode register
//
// Ports
//   clock         master DSP clock (clk64), rising edge
//   reset         synchronous active-high reset (rx_dsp_reset)
//   enable        enable_rx; generators are held at their seeds while low
//   serial_strobe settings write strobe
//   serial_addr   settings address
//   serial_data   settings data; bits [2k+1:2k] are the mode of channel k
//   in_strobe     sample strobe (hb_strobe), one-cycle pulse
//   rx_in         DDC samples, channel k at [k*WIDTH +: WIDTH]
//   tx_strobe     interpolator strobe qualifying tx_in
//   tx_in         TX baseband samples for loopback
//   rx_out        selected samples, registered
//   out_strobe    one-cycle pulse when rx_out has been updated
//   active_modes  modes currently applied, for serial readback

module rx_source_sel #(
  parameter int         NCHAN = 8,
  parameter int         WIDTH = 16,
  parameter logic [6:0] ADDR  = 7'd50
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   serial_strobe,
  input  logic [6:0]             serial_addr,
  input  logic [31:0]            serial_data,
  input  logic                   in_strobe,
  input  logic [NCHAN*WIDTH-1:0] rx_in,
  input  logic                   tx_strobe,
  input  logic [NCHAN*WIDTH-1:0] tx_in,
  output logic [NCHAN*WIDTH-1:0] rx_out,
  output logic                   out_strobe,
  output logic [2*NCHAN-1:0]     active_modes
);

  localparam int MW = 2 * NCHAN;

  localparam logic [1:0] MODE_DDC  = 2'd0;
  localparam logic [1:0] MODE_LOOP = 2'd1;
  localparam logic [1:0] MODE_CNT  = 2'd2;
  localparam logic [1:0] MODE_PRBS = 2'd3;

  localparam logic [14:0] LFSR_SEED = 15'h0001;

  // Control state
  logic [MW-1:0]          active;
  logic [MW-1:0]          pending;
  logic                   pending_valid;
  logic                   vld_p0;

  // Generator and loopback state
  logic [WIDTH-1:0]       cnt;
  logic [14:0]            lfsr;
  logic [NCHAN*WIDTH-1:0] tx_lat;

  // Selection result feeding the output register
  logic [MW-1:0]          eff_mode;
  logic [NCHAN*WIDTH-1:0] sel_data;
  logic                   take;
  logic                   write_hit;

  // x^15 + x^14 + 1 Fibonacci step; the feedback bit enters at bit 0.
  function automatic logic [14:0] lfsr_step(input logic [14:0] s);
    return {s[13:0], s[14] ^ s[13]};
  endfunction

  // Ramp value for channel k: channels of one strobe read consecutive values.
  function automatic logic [WIDTH-1:0] ramp_value(input logic [WIDTH-1:0] base,
                                                  input int unsigned k);
    return base + WIDTH'(k);
  endfunction

  // Per-channel source multiplexer.
  function automatic logic [WIDTH-1:0] pick_source(input logic [1:0]       mode,
                                                   input logic [WIDTH-1:0] ddc,
                                                   input logic [WIDTH-1:0] loop,
                                                   input logic [WIDTH-1:0] ramp,
                                                   input logic [14:0]      prbs);
    logic [WIDTH-1:0] r;
    r = ddc;
    case (mode)
      MODE_DDC:  r = ddc;
      MODE_LOOP: r = loop;
      MODE_CNT:  r = ramp;
      MODE_PRBS: r = WIDTH'(prbs);
      default:   r = ddc;
    endcase
    return r;
  endfunction

  assign write_hit = serial_strobe && (serial_addr == ADDR);
  assign take      = in_strobe && enable;

  // A write that has not yet met a strobe overrides the applied modes, so the
  // first strobe after the write already uses it.
  assign eff_mode  = pending_valid ? pending : active;

  // ---- stage p0: combinational selection from current state ----
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NCHAN; k++) begin
      sel_data[k*WIDTH +: WIDTH] = pick_source(eff_mode[2*k +: 2],
                                               rx_in[k*WIDTH +: WIDTH],
                                               tx_lat[k*WIDTH +: WIDTH],
                                               ramp_value(cnt, k),
                                               lfsr);
    end
  end

  // ---- stage p1: registered outputs and state update ----
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_out        <= '0;
      vld_p0        <= 1'b0;
      active        <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
      cnt           <= '0;
      lfsr          <= LFSR_SEED;
      tx_lat        <= '0;
    end else begin
      vld_p0 <= take;

      if (take) begin
        rx_out        <= sel_data;
        active        <= eff_mode;
        pending_valid <= 1'b0;
        cnt           <= cnt + WIDTH'(NCHAN);
        lfsr          <= lfsr_step(lfsr);
      end

      // Disabled: generators restart from their seeds on re-enable.
      if (!enable) begin
        cnt  <= '0;
        lfsr <= LFSR_SEED;
      end

      // Placed after the strobe clear so a write coinciding with a strobe
      // stays pending for the next one.
      if (write_hit) begin
        pending       <= serial_data[MW-1:0];
        pending_valid <= 1'b1;
      end

      // Same-cycle strobe reads the old latch; the new value is used later.
      if (tx_strobe) begin
        tx_lat <= tx_in;
      end
    end
  end

  assign out_strobe   = vld_p0;
  assign active_modes = active;

endmodule

// File: tb/tb_rx_source_sel.sv
module tb_rx_source_sel;

  localparam int NCH = 8;
  localparam int W   = 16;

  logic              clock = 1'b0;
  logic              reset;
  logic              enable;
  logic              serial_strobe;
  logic [6:0]        serial_addr;
  logic [31:0]       serial_data;
  logic              in_strobe;
  logic [NCH*W-1:0]  rx_in;
  logic              tx_strobe;
  logic [NCH*W-1:0]  tx_in;
  logic [NCH*W-1:0]  rx_out;
  logic              out_strobe;
  logic [2*NCH-1:0]  active_modes;

  rx_source_sel #(.NCHAN(NCH), .WIDTH(W), .ADDR(7'd50)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .serial_strobe(serial_strobe), .serial_addr(serial_addr),
    .serial_data(serial_data), .in_strobe(in_strobe), .rx_in(rx_in),
    .tx_strobe(tx_strobe), .tx_in(tx_in), .rx_out(rx_out),
    .out_strobe(out_strobe), .active_modes(active_modes)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: expected outputs derived from strobe counts.
  logic [15:0]      prbs_seq [32767];
  logic [NCH*W-1:0] m_out;
  logic             m_ostb;
  logic [15:0]      m_active;
  logic [15:0]      m_pend;
  logic             m_pv;
  int               m_n;       // enabled strobes since reset / last disable
  logic [NCH*W-1:0] m_tx;

  task automatic model_reset();
    m_out = '0; m_ostb = 1'b0; m_active = '0; m_pend = '0; m_pv = 1'b0;
    m_n = 0; m_tx = '0;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock: update the model from the inputs, then compare.
  task automatic cyc();
    logic [15:0] eff;
    if (reset) begin
      model_reset();
    end else begin
      eff = m_pv ? m_pend : m_active;
      m_ostb = in_strobe && enable;
      if (in_strobe && enable) begin
        for (int k = 0; k < NCH; k++) begin
          case (eff[2*k +: 2])
            2'd0: m_out[k*W +: W] = rx_in[k*W +: W];
            2'd1: m_out[k*W +: W] = m_tx[k*W +: W];
            2'd2: m_out[k*W +: W] = 16'((m_n * NCH + k) % 65536);
            default: m_out[k*W +: W] = prbs_seq[m_n % 32767];
          endcase
        end
        m_active = eff;
        m_pv = 1'b0;
        m_n++;
      end
      if (!enable) m_n = 0;
      if (serial_strobe && serial_addr == 7'd50) begin
        m_pend = serial_data[15:0];
        m_pv = 1'b1;
      end
      if (tx_strobe) m_tx = tx_in;
    end
    @(posedge clock);
    #1;
    check("model_rx_out", 128'(rx_out), 128'(m_out));
    check("model_out_strobe", 128'(out_strobe), 128'(m_ostb));
    check("model_active_modes", 128'(active_modes), 128'(m_active));
  endtask

  task automatic drive(input logic ins, input logic wr, input logic [31:0] wd, input logic txs);
    in_strobe = ins; serial_strobe = wr; serial_addr = 7'd50; serial_data = wd; tx_strobe = txs;
    cyc();
    in_strobe = 1'b0; serial_strobe = 1'b0; tx_strobe = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    reset = 1'b0;
  endtask

  function automatic logic [15:0] ch(input int k);
    return rx_out[k*W +: W];
  endfunction

  initial begin
    logic [14:0] s;
    int strobes;
    s = 15'h0001;
    for (int i = 0; i < 32767; i++) begin
      prbs_seq[i] = {1'b0, s};
      s = {s[13:0], s[14] ^ s[13]};
    end

    reset = 1'b1; enable = 1'b1; serial_strobe = 1'b0; serial_addr = 7'd0;
    serial_data = '0; in_strobe = 1'b0; rx_in = '0; tx_strobe = 1'b0; tx_in = '0;
    model_reset();
    do_reset();
    check("reset_rx_out", 128'(rx_out), 128'd0);
    check("reset_active", 128'(active_modes), 128'd0);
    check("reset_ostb", 128'(out_strobe), 128'd0);

    // Default DDC path
    rx_in[15:0] = 16'h1234;
    drive(1, 0, 0, 0);
    check("ddc_ch0", 128'(ch(0)), 128'h1234);
    check("ddc_ostb", 128'(out_strobe), 128'd1);
    check("ddc_active", 128'(active_modes), 128'd0);
    drive(0, 0, 0, 0);
    check("ostb_width", 128'(out_strobe), 128'd0);

    // Deferred mode change
    tx_in[15:0] = 16'h00A5;
    drive(0, 0, 0, 1);
    rx_in[15:0] = 16'h7777;
    drive(1, 1, 32'h0001, 0);
    check("defer_still_ddc", 128'(ch(0)), 128'h7777);
    check("defer_active_old", 128'(active_modes), 128'd0);
    drive(1, 0, 0, 0);
    check("defer_loop", 128'(ch(0)), 128'h00A5);
    check("defer_active_new", 128'(active_modes[1:0]), 128'd1);

    // Loopback ordering
    tx_in[15:0] = 16'h005A;
    drive(1, 0, 0, 1);
    check("loop_old_latch", 128'(ch(0)), 128'h00A5);
    drive(1, 0, 0, 0);
    check("loop_new_latch", 128'(ch(0)), 128'h005A);

    // Counter mode and wrap
    do_reset();
    drive(0, 1, 32'h0000AAAA, 0);
    for (int r = 0; r < 3; r++) begin
      drive(1, 0, 0, 0);
      for (int k = 0; k < NCH; k++) check("cnt_ramp", 128'(ch(k)), 128'(r * 8 + k));
    end
    for (int i = 0; i < 8188; i++) drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    check("cnt_wrap_ch7", 128'(ch(7)), 128'hFFFF);
    drive(1, 0, 0, 0);
    check("cnt_wrap_ch0", 128'(ch(0)), 128'h0000);

    // Enable drop
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 0);
      check("disabled_ostb", 128'(out_strobe), 128'd0);
    end
    enable = 1'b1;
    drive(1, 0, 0, 0);
    for (int k = 0; k < NCH; k++) check("reenable_cnt", 128'(ch(k)), 128'(k));

    // PRBS sequence on channel 0
    do_reset();
    drive(0, 1, 32'h00000003, 0);
    for (int i = 0; i < 14; i++) begin
      drive(1, 0, 0, 0);
      check("prbs_walk", 128'(ch(0)), 128'(16'h0001 << i));
    end
    drive(1, 0, 0, 0);
    check("prbs_feedback", 128'(ch(0)), 128'h4001);

    // Randomized long run with channel 0 kept in PRBS mode
    strobes = 0;
    while (strobes < 40000) begin
      in_strobe = ($urandom_range(0, 9) != 0);
      for (int k = 0; k < NCH; k++) begin
        rx_in[k*W +: W] = 16'($urandom);
        tx_in[k*W +: W] = 16'($urandom);
      end
      tx_strobe = ($urandom_range(0, 3) == 0);
      serial_strobe = ($urandom_range(0, 15) == 0);
      serial_addr = ($urandom_range(0, 3) == 0) ? 7'd51 : 7'd50;
      serial_data = $urandom | 32'h3;
      if (in_strobe) strobes++;
      cyc();
    end

    // Randomized phase with enable drops, resets and arbitrary modes
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 499) == 0);
      enable = ($urandom_range(0, 19) != 0);
      in_strobe = ($urandom_range(0, 2) != 0);
      for (int k = 0; k < NCH; k++) begin
        rx_in[k*W +: W] = 16'($urandom);
        tx_in[k*W +: W] = 16'($urandom);
      end
      tx_strobe = ($urandom_range(0, 2) == 0);
      serial_strobe = ($urandom_range(0, 7) == 0);
      serial_addr = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'd50;
      serial_data = $urandom;
      cyc();
    end
    reset = 1'b0; enable = 1'b1;
    in_strobe = 1'b0; serial_strobe = 1'b0; tx_strobe = 1'b0;
    drive(0, 0, 0, 0);

    // Reset with a write pending
    drive(0, 1, 32'h0000FFFF, 0);
    reset = 1'b1;
    drive(0, 0, 0, 0);
    check("rst_pend_rx_out", 128'(rx_out), 128'd0);
    check("rst_pend_active", 128'(active_modes), 128'd0);
    check("rst_pend_ostb", 128'(out_strobe), 128'd0);
    reset = 1'b0;
    rx_in[15:0] = 16'h4321;
    drive(1, 0, 0, 0);
    check("rst_pend_discard_ch0", 128'(ch(0)), 128'h4321);
    check("rst_pend_discard_active", 128'(active_modes), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
